// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register file: WAIT_CYCLES+2 cycles per transfer.
// PREADY stays low for WAIT_CYCLES access cycles; dropping PSEL mid-access abandons the transfer.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB     = DATA_WIDTH / 8;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt;
  logic                  wr_q, err_q;
  logic [MEM_AW-1:0]     idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  err;
  logic                  setup;
  logic                  complete;

  assign idx      = PADDR[ADDR_WIDTH-1:2];
  assign mem_idx  = idx[MEM_AW-1:0];
  assign err      = (PADDR[1:0] != 2'b00) || (32'(idx) >= 32'(DEPTH));
  assign setup    = (state == IDLE) && PSEL && !PENABLE;
  assign complete = (state == ACCESS) && PSEL && PENABLE && PREADY;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      ACCESS:  if (!PSEL || (PENABLE && PREADY)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PREADY  = (state == ACCESS) && (wait_cnt == 4'd0);
    PSLVERR = PREADY && err_q;
    PRDATA  = rdata_q;
  end

  // Read data is fetched at the setup edge so it is ready however short the access phase is.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt <= 4'd0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
    end else if (setup) begin
      wait_cnt <= 4'(WAIT_CYCLES);
      wr_q     <= PWRITE;
      err_q    <= err;
      idx_q    <= mem_idx;
      wdata_q  <= PWDATA;
      strb_q   <= PSTRB;
      if (!PWRITE) rdata_q <= err ? '0 : mem[mem_idx];
    end else if ((state == ACCESS) && PSEL && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (complete && wr_q && !err_q) begin
      for (int b = 0; b < NB; b++)
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: four completers (waits 1/3/0 and a 9-bit address variant) on one shared bus,
// only one selected at a time; expected values are hand-computed in the vector table.
module tb_apb_slave_mem;

  logic        clk;
  logic        preset;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [8:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [4];
  logic [3:0]  pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;
  int wait_of [4] = '{1, 3, 0, 1};

  apb_slave_mem #(.ADDR_WIDTH(8), .WAIT_CYCLES(1)) u0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr[7:0]), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_slave_mem #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u1 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr[7:0]), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_slave_mem #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u2 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr[7:0]), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));
  apb_slave_mem #(.ADDR_WIDTH(9), .WAIT_CYCLES(1)) u3 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[3]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[3]), .PREADY(pready[3]), .PSLVERR(pslverr[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the completion cycle.
  task automatic xfer(input int u, input logic wr, input logic [8:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err,
                      input string name);
    int waits;
    psel[u] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    pwdata  = ~wd;          // only setup-phase write data may land in memory
    pstrb   = 4'hF;
    waits   = 0;
    while (!pready[u] && waits < 40) begin
      chk({name, "_wait_err"}, 32'(pslverr[u]), 32'd0);
      waits++;
      @(negedge clk);
    end
    chk({name, "_ready"}, 32'(pready[u]), 32'd1);
    chk({name, "_waits"}, 32'(waits), 32'(wait_of[u]));
    chk({name, "_slverr"}, 32'(pslverr[u]), 32'(exp_err));
    if (!wr) chk({name, "_rdata"}, prdata[u], exp_rd);
    @(negedge clk);
    psel[u] = 1'b0; penable = 1'b0;
    chk({name, "_ready_after"}, 32'(pready[u]), 32'd0);
  endtask

  typedef struct {
    int          u;
    logic        wr;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{0, 1'b0, 9'h010, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[1]  = '{0, 1'b1, 9'h004, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[2]  = '{0, 1'b0, 9'h004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{0, 1'b1, 9'h008, 32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[4]  = '{0, 1'b1, 9'h008, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[5]  = '{0, 1'b0, 9'h008, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[6]  = '{0, 1'b0, 9'h006, 32'h0,        4'h0, 32'h00000000, 1'b1};
    tbl[7]  = '{0, 1'b1, 9'h006, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    tbl[8]  = '{0, 1'b0, 9'h004, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[9]  = '{3, 1'b0, 9'h100, 32'h0,        4'h0, 32'h00000000, 1'b1};
    tbl[10] = '{3, 1'b1, 9'h100, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1};
    tbl[11] = '{3, 1'b0, 9'h000, 32'h0,        4'h0, 32'h00000000, 1'b0};
    tbl[12] = '{3, 1'b1, 9'h0FC, 32'h0BADC0DE, 4'hF, 32'h0,        1'b0};
    tbl[13] = '{3, 1'b0, 9'h0FC, 32'h0,        4'h0, 32'h0BADC0DE, 1'b0};
    tbl[14] = '{2, 1'b1, 9'h000, 32'h00001111, 4'hF, 32'h0,        1'b0};
    tbl[15] = '{2, 1'b1, 9'h004, 32'h22223333, 4'hF, 32'h0,        1'b0};
    tbl[16] = '{2, 1'b1, 9'h008, 32'h44445555, 4'hF, 32'h0,        1'b0};
    tbl[17] = '{2, 1'b1, 9'h00C, 32'h66667777, 4'hF, 32'h0,        1'b0};
    tbl[18] = '{2, 1'b0, 9'h000, 32'h0,        4'h0, 32'h00001111, 1'b0};
    tbl[19] = '{2, 1'b0, 9'h004, 32'h0,        4'h0, 32'h22223333, 1'b0};
    tbl[20] = '{2, 1'b0, 9'h008, 32'h0,        4'h0, 32'h44445555, 1'b0};
    tbl[21] = '{2, 1'b0, 9'h00C, 32'h0,        4'h0, 32'h66667777, 1'b0};
    tbl[22] = '{2, 1'b0, 9'h001, 32'h0,        4'h0, 32'h00000000, 1'b1};

    preset = 1'b1; psel = 4'h0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      chk($sformatf("rst_ready%0d", u), 32'(pready[u]), 32'd0);
      chk($sformatf("rst_slverr%0d", u), 32'(pslverr[u]), 32'd0);
      chk($sformatf("rst_rdata%0d", u), prdata[u], 32'd0);
    end
    preset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 4; u++)
      chk($sformatf("post_rst_ready%0d", u), 32'(pready[u]), 32'd0);

    for (int i = 0; i < NV; i++)
      xfer(tbl[i].u, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].st, tbl[i].rd, tbl[i].err,
           $sformatf("v%0d", i));

    // PENABLE without a setup phase must leave the completer idle.
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 9'h004;
    @(negedge clk);
    chk("penable_in_idle", 32'(pready[0]), 32'd0);
    psel[0] = 1'b0; penable = 1'b0;
    @(negedge clk);

    xfer(1, 1'b1, 9'h010, 32'h12345678, 4'hF, 32'h0, 1'b0, "w3_wr");
    xfer(1, 1'b0, 9'h010, 32'h0, 4'h0, 32'h12345678, 1'b0, "w3_rd");

    // Abort: PSEL dropped in the second wait cycle.
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h00C; pwdata = 32'h55; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    chk("abort_wait1", 32'(pready[1]), 32'd0);
    @(negedge clk);
    chk("abort_wait2", 32'(pready[1]), 32'd0);
    psel[1] = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(pready[1]), 32'd0);
    xfer(1, 1'b0, 9'h00C, 32'h0, 4'h0, 32'h0, 1'b0, "abort_rd");
    xfer(1, 1'b0, 9'h010, 32'h0, 4'h0, 32'h12345678, 1'b0, "pre_rst_rd");

    // Reset pulsed in a wait cycle of a write.
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h00C; pwdata = 32'h77; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    preset = 1'b0; psel[1] = 1'b0; penable = 1'b0;
    chk("midrst_ready", 32'(pready[1]), 32'd0);
    chk("midrst_slverr", 32'(pslverr[1]), 32'd0);
    chk("midrst_rdata", prdata[1], 32'd0);
    chk("midrst_rdata_u0", prdata[0], 32'd0);
    @(negedge clk);
    xfer(1, 1'b0, 9'h00C, 32'h0, 4'h0, 32'h0, 1'b0, "midrst_rd0c");
    xfer(1, 1'b0, 9'h010, 32'h0, 4'h0, 32'h0, 1'b0, "midrst_rd10");
    xfer(1, 1'b1, 9'h00C, 32'h99, 4'hF, 32'h0, 1'b0, "midrst_wr");
    xfer(1, 1'b0, 9'h00C, 32'h0, 4'h0, 32'h99, 1'b0, "midrst_rdback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
